// File: rtl/bcrypt_core_rx.sv
// Core-side receiver for the 10-bit batch bus. Reassembles LSB-first bytes
// into 32-bit words and issues single-word writes for init and data transfers.
// Protocol errors are sticky and park the FSM in ST_ERROR until reset.
module bcrypt_core_rx #(
    parameter int INIT_WORDS = 1054,
    parameter int P_WORDS    = 30,
    parameter int S_BASE     = 1024,
    parameter int DATA_WORDS = 31,
    parameter int DATA_BASE  = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [7:0]            din,
    input  logic [1:0]            ctrl,
    input  logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  init_done,
    output logic                  data_done,
    output logic                  busy,
    output logic [2:0]            error
);

    localparam logic [1:0] CTRL_IDLE       = 2'd0;
    localparam logic [1:0] CTRL_INIT_START = 2'd1;
    localparam logic [1:0] CTRL_DATA_START = 2'd2;
    localparam logic [1:0] CTRL_END        = 2'd3;

    // Word counter only has to reach INIT_WORDS-1.
    localparam int WCW = $clog2(INIT_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX_INIT,
        ST_RX_DATA,
        ST_ERROR
    } state_t;

    state_t                state_q;
    logic [1:0]            byte_cnt_q;
    logic [WCW-1:0]        word_cnt_q;
    // Holds the three most recent bytes; the incoming byte completes the word.
    logic [23:0]           word_q;
    logic [31:0]           word_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  last_word;

    // Word assembly, target address and "this is the final word" decode.
    always_comb begin
        word_d = {din, word_q};
        if (state_q == ST_RX_INIT) begin
            last_word = (word_cnt_q == WCW'(INIT_WORDS - 1));
            // P/reserved/MW land linearly at 0; S words are relocated to S_BASE.
            if (word_cnt_q < WCW'(P_WORDS))
                addr_d = ADDR_WIDTH'(word_cnt_q);
            else
                addr_d = ADDR_WIDTH'(word_cnt_q + WCW'(S_BASE - P_WORDS));
        end else begin
            last_word = (word_cnt_q == WCW'(DATA_WORDS - 1));
            addr_d    = ADDR_WIDTH'(word_cnt_q + WCW'(DATA_BASE));
        end
    end

    // Receive FSM with registered write strobe, done pulses, busy and error.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            init_done  <= 1'b0;
            data_done  <= 1'b0;
            busy       <= 1'b0;
            error      <= '0;
        end else begin
            wr_en     <= 1'b0;
            init_done <= 1'b0;
            data_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    byte_cnt_q <= '0;
                    word_cnt_q <= '0;
                    case (ctrl)
                        CTRL_INIT_START, CTRL_DATA_START: begin
                            if (!rx_ready) begin
                                error[2] <= 1'b1;
                                state_q  <= ST_ERROR;
                            end else begin
                                state_q <= (ctrl == CTRL_INIT_START) ? ST_RX_INIT : ST_RX_DATA;
                                busy    <= 1'b1;
                            end
                        end
                        CTRL_END: begin
                            error[1] <= 1'b1;
                            state_q  <= ST_ERROR;
                        end
                        CTRL_IDLE: ;
                        default: ;
                    endcase
                end
                ST_RX_INIT, ST_RX_DATA: begin
                    if (ctrl == CTRL_INIT_START || ctrl == CTRL_DATA_START) begin
                        // A START cycle carries no byte, so nothing is shifted.
                        error[1] <= 1'b1;
                        state_q  <= ST_ERROR;
                        busy     <= 1'b0;
                    end else begin
                        word_q     <= word_d[31:8];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (ctrl == CTRL_END) begin
                            busy <= 1'b0;
                            if (byte_cnt_q == 2'd3 && last_word) begin
                                wr_en     <= 1'b1;
                                wr_addr   <= addr_d;
                                wr_data   <= word_d;
                                init_done <= (state_q == ST_RX_INIT);
                                data_done <= (state_q == ST_RX_DATA);
                                state_q   <= ST_IDLE;
                            end else begin
                                // Short/misaligned transfer: partial word dropped.
                                error[0] <= 1'b1;
                                state_q  <= ST_ERROR;
                            end
                        end else if (byte_cnt_q == 2'd3) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= addr_d;
                            wr_data    <= word_d;
                            word_cnt_q <= word_cnt_q + WCW'(1);
                            if (last_word) begin
                                // Final word arrived without END: stop before overrunning.
                                error[0] <= 1'b1;
                                state_q  <= ST_ERROR;
                                busy     <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
